// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port SPI RAM: deserialises select+payload
// frames, pulses rx_valid, and serialises RAM read bytes on MISO. Optional macro: SPI_TX_TIMEOUT_EN.
module spi_slave_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD,
    RD_SHIFT_IN, RD_WAIT_TX, RD_SHIFT_OUT, RD_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d, rx_valid_q, rx_valid_d;
  logic              rd_flag_q, rd_flag_d, wait_seen_q, wait_seen_d;
`ifdef SPI_TX_TIMEOUT_EN
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  logic [TW-1:0]     tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    tx_sh_d     = tx_sh_q;
    miso_d      = 1'b0;
    rx_valid_d  = 1'b0;
    rd_flag_d   = rd_flag_q;
    wait_seen_d = wait_seen_q;
`ifdef SPI_TX_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    // Deselect beats everything, including a frame's final bit.
    if (state_q != IDLE && SS_n) begin
      state_d     = IDLE;
      cnt_d       = '0;
      wait_seen_d = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      tmo_d       = '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (!SS_n) begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          if (!MOSI)          state_d = WRITE;
          else if (rd_flag_q) state_d = RD_SHIFT_IN;
          else                state_d = READ_ADD;
        end
        WRITE, READ_ADD, RD_SHIFT_IN: begin
          if (cnt_q < CW'(FW)) begin
            rx_sh_d = {rx_sh_q[FW-2:0], MOSI};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(FW - 1)) begin
              rx_data_d  = {rx_sh_q[FW-2:0], MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)    rd_flag_d = 1'b1;
              if (state_q == RD_SHIFT_IN) rd_flag_d = 1'b0;
            end
          end else if (state_q == RD_SHIFT_IN) begin
            // The rx_valid cycle is over; the RAM answers from here on.
            state_d     = RD_WAIT_TX;
            wait_seen_d = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end
        end
        RD_WAIT_TX: begin
          wait_seen_d = 1'b1;
          // First WAIT_TX cycle may still show a stale RAM output.
          if (wait_seen_q && tx_valid) begin
            state_d = RD_SHIFT_OUT;
            miso_d  = tx_data[DATA_W-1];
            tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
            cnt_d   = CW'(1);
          end
`ifdef SPI_TX_TIMEOUT_EN
          else if (tmo_q == TW'(TX_TIMEOUT - 1)) begin
            state_d = RD_DONE;
          end
          tmo_d = tmo_q + TW'(1);
`endif
        end
        RD_SHIFT_OUT: begin
          if (cnt_q < CW'(DATA_W)) begin
            miso_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end else begin
            state_d = RD_DONE;
          end
        end
        RD_DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      tx_sh_q     <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rd_flag_q   <= 1'b0;
      wait_seen_q <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      rd_flag_q   <= rd_flag_d;
      wait_seen_q <= wait_seen_d;
`ifdef SPI_TX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: table of frames, rx_data scoreboard, MISO byte checks.
module tb_spi_slave_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  spi_slave_ctrl #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [9:0] exp_q[$];
  logic       prev_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (rst_n && rx_valid) begin
      chk("rx_valid_single", {31'd0, prev_v}, 32'd0);
      if (exp_q.size() == 0) chk("rx_unexpected", {22'd0, rx_data}, 32'hFFFF_FFFF);
      else                   chk("rx_data", {22'd0, rx_data}, {22'd0, exp_q.pop_front()});
    end
    prev_v = rx_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic frame(input logic sel, input logic [9:0] pl, input int nbits, input bit ab_last);
    if (nbits == 10 && !ab_last) exp_q.push_back(pl);
    SS_n = 1'b0; @(negedge clk);
    MOSI = sel;  @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = pl[9-i];
      if (ab_last && i == nbits - 1) SS_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1; tx_valid = 1'b0; MOSI = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // MISO must stay 0 even with a valid RAM byte on offer.
  task automatic quiet(input string nm);
    int ones = 0;
    tx_data = 8'hFF; tx_valid = 1'b1;
    repeat (14) begin @(posedge clk); #1 ones += int'(MISO); end
    chk(nm, ones, 0);
    @(negedge clk);
  endtask

  task automatic rd_out(input logic [7:0] exp, input int skip);
    logic [7:0] got = '0;
    repeat (skip) @(posedge clk);
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1 got = {got[6:0], MISO}; end
    chk("miso_byte", {24'd0, got}, {24'd0, exp});
    @(posedge clk); #1 chk("miso_done", {31'd0, MISO}, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic       sel;
    logic [9:0] pl;
    int         nbits;
    bit         ab_last;
    int         extra;
    int         mode;   // 0 none, 1 expect silent MISO, 2 expect tx byte on MISO
    logic [7:0] tx;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 10'h0A5, 10, 1'b0, 0, 1, 8'h00};
    vecs[1] = '{1'b0, 10'h13C, 10, 1'b0, 3, 1, 8'h00};
    vecs[2] = '{1'b1, 10'h207, 10, 1'b0, 0, 1, 8'h00};
    vecs[3] = '{1'b1, 10'h300, 10, 1'b0, 0, 2, 8'hC3};
    vecs[4] = '{1'b1, 10'h2AA, 10, 1'b0, 0, 1, 8'h00};
    vecs[5] = '{1'b1, 10'h355, 10, 1'b0, 0, 2, 8'h96};
    vecs[6] = '{1'b1, 10'h2F5,  6, 1'b0, 0, 0, 8'h00};
    vecs[7] = '{1'b1, 10'h2F0, 10, 1'b0, 0, 1, 8'h00};
    vecs[8] = '{1'b1, 10'h3FF, 10, 1'b1, 0, 0, 8'h00};
    vecs[9] = '{1'b1, 10'h301, 10, 1'b0, 0, 2, 8'h01};

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      frame(vecs[k].sel, vecs[k].pl, vecs[k].nbits, vecs[k].ab_last);
      for (int j = 0; j < vecs[k].extra; j++) begin MOSI = 1'b1; @(negedge clk); end
      if (vecs[k].mode == 1) quiet("miso_silent");
      else if (vecs[k].mode == 2) begin
        tx_data = vecs[k].tx; tx_valid = 1'b1;
        rd_out(vecs[k].tx, 2);
      end
      end_frame();
    end

    // Stale RAM output during the rx_valid cycle must not be captured.
    frame(1'b1, 10'h2C0, 10, 1'b0); end_frame();
    tx_data = 8'h11; tx_valid = 1'b1;
    frame(1'b1, 10'h3C0, 10, 1'b0);
    @(negedge clk); tx_data = 8'h5A;
    rd_out(8'h5A, 1);
    end_frame();

    // Reset after three MISO bits.
    frame(1'b1, 10'h2C1, 10, 1'b0); end_frame();
    frame(1'b1, 10'h3C1, 10, 1'b0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_miso", {31'd0, MISO}, 32'd0);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    frame(1'b1, 10'h2C2, 10, 1'b0);
    quiet("post_rst_read_add");
    end_frame();

`ifdef SPI_TX_TIMEOUT_EN
    frame(1'b1, 10'h3C2, 10, 1'b0);
    repeat (20) @(negedge clk);
    quiet("timeout_done");
    end_frame();
`endif

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
